// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported shared memory.
// Each grant runs IDLE -> ISSUE -> ACK. Every output comes straight from a register.
module memory_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  owner
);

  typedef enum logic [1:0] {StIdle, StIssue, StAck} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  owner_q, owner_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic                  a_ack_q, a_ack_d;
  logic                  b_ack_q, b_ack_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic                  win_b;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    owner_d   = owner_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    mem_en_d  = 1'b0;
    mem_we_d  = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    // On contention the port that was not granted last wins; otherwise the sole requester wins.
    win_b     = (a_req && b_req) ? ~owner_q : b_req;

    unique case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          owner_d  = win_b;
          we_d     = win_b ? b_we : a_we;
          addr_d   = win_b ? b_addr : a_addr;
          wdata_d  = win_b ? b_wdata : a_wdata;
          mem_en_d = 1'b1;
          mem_we_d = win_b ? b_we : a_we;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        state_d = StAck;
        if (owner_q) begin
          b_ack_d = 1'b1;
          if (!we_q) b_rdata_d = mem_rdata;
        end else begin
          a_ack_d = 1'b1;
          if (!we_q) a_rdata_d = mem_rdata;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      owner_q   <= 1'b1;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      owner_q   <= owner_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = owner_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter backed by a small behavioural memory.
// Memory reads are combinational; writes happen on mem_en & mem_we.
module tb_memory_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic [DW-1:0] a_rdata;
  logic          a_ack;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic [DW-1:0] b_rdata;
  logic          b_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          owner;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_rdata   (a_rdata),
    .a_ack     (a_ack),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_rdata   (b_rdata),
    .b_ack     (b_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3 reset = 1'b0;
    pre_we = 1'b1; pre_addr = 10'h005; pre_data = 16'h8000;
    tick();
    pre_addr = 10'h003; pre_data = 16'h1111;
    tick();
    pre_we = 1'b0;
    tick();

    // Reset values
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_a_ack", a_ack, 0);
    check_eq("rst_b_ack", b_ack, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_a_rdata", a_rdata, 0);
    check_eq("rst_b_rdata", b_rdata, 0);
    check_eq("rst_owner", owner, 1);

    // Single read on A
    reset = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h005;
    tick();
    check_eq("rd_mem_en", mem_en, 1);
    check_eq("rd_mem_we", mem_we, 0);
    check_eq("rd_mem_addr", mem_addr, 10'h005);
    check_eq("rd_owner", owner, 0);
    check_eq("rd_a_ack_early", a_ack, 0);
    tick();
    check_eq("rd_a_ack", a_ack, 1);
    check_eq("rd_a_rdata", a_rdata, 16'h8000);
    check_eq("rd_mem_en_off", mem_en, 0);
    check_eq("rd_b_rdata_loser", b_rdata, 0);
    a_req = 1'b0;
    tick();
    check_eq("rd_a_ack_once", a_ack, 0);
    tick();
    check_eq("rd_idle_en", mem_en, 0);

    // Single write on B
    b_req = 1'b1; b_we = 1'b1; b_addr = 10'h00A; b_wdata = 16'h1234;
    tick();
    check_eq("wr_mem_en", mem_en, 1);
    check_eq("wr_mem_we", mem_we, 1);
    check_eq("wr_mem_addr", mem_addr, 10'h00A);
    check_eq("wr_mem_wdata", mem_wdata, 16'h1234);
    check_eq("wr_owner", owner, 1);
    tick();
    check_eq("wr_b_ack", b_ack, 1);
    check_eq("wr_b_rdata_kept", b_rdata, 0);
    check_eq("wr_mem_we_off", mem_we, 0);
    check_eq("wr_a_ack_loser", a_ack, 0);
    check_eq("wr_a_rdata_loser", a_rdata, 16'h8000);
    b_req = 1'b0; b_we = 1'b0;
    tick();
    check_eq("wr_mem_content", mem[10'h00A], 16'h1234);

    // B alone wins again despite having the last grant
    b_req = 1'b1;
    tick();
    check_eq("rb_owner", owner, 1);
    check_eq("rb_mem_addr", mem_addr, 10'h00A);
    tick();
    check_eq("rb_b_ack", b_ack, 1);
    check_eq("rb_b_rdata", b_rdata, 16'h1234);
    b_req = 1'b0;
    tick();

    // Contention right after reset: A first, then B
    reset = 1'b0;
    tick();
    a_req = 1'b1; a_addr = 10'h005;
    b_req = 1'b1; b_addr = 10'h00A;
    reset = 1'b1;
    tick();
    check_eq("ct_owner_a", owner, 0);
    check_eq("ct_addr_a", mem_addr, 10'h005);
    tick();
    check_eq("ct_a_ack", a_ack, 1);
    check_eq("ct_a_rdata", a_rdata, 16'h8000);
    a_req = 1'b0;
    tick();
    check_eq("ct_idle_gap", mem_en, 0);
    tick();
    check_eq("ct_owner_b", owner, 1);
    check_eq("ct_addr_b", mem_addr, 10'h00A);
    check_eq("ct_en_b", mem_en, 1);
    tick();
    check_eq("ct_b_ack", b_ack, 1);
    check_eq("ct_b_rdata", b_rdata, 16'h1234);
    b_req = 1'b0;
    tick();

    // Sustained contention: grants A,B,A,B at edges 1,4,7,10; acks one edge later
    a_req = 1'b1; b_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_eq($sformatf("rr_a_ack_%0d", k), a_ack, (k == 2 || k == 8) ? 1 : 0);
      check_eq($sformatf("rr_b_ack_%0d", k), b_ack, (k == 5 || k == 11) ? 1 : 0);
      check_eq($sformatf("rr_en_%0d", k), mem_en, (k % 3 == 1) ? 1 : 0);
      if (k % 3 == 1)
        check_eq($sformatf("rr_owner_%0d", k), owner, (k == 4 || k == 10) ? 1 : 0);
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    check_eq("rr_stop", mem_en, 0);

    // A withdraws during ISSUE: transaction still completes, no repeat
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h003;
    tick();
    check_eq("wd_en", mem_en, 1);
    a_req = 1'b0; a_addr = 10'h005;
    tick();
    check_eq("wd_a_ack", a_ack, 1);
    check_eq("wd_a_rdata", a_rdata, 16'h1111);
    check_eq("wd_addr_held", mem_addr, 10'h003);
    tick();
    check_eq("wd_a_ack_once", a_ack, 0);
    tick();
    check_eq("wd_no_repeat_en", mem_en, 0);
    tick();
    check_eq("wd_no_repeat_ack", a_ack, 0);

    // Reset during ISSUE of a write
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h003; a_wdata = 16'hBEEF;
    tick();
    check_eq("rs_mem_we_pre", mem_we, 1);
    #1 reset = 1'b0;
    #1;
    check_eq("rs_mem_we", mem_we, 0);
    check_eq("rs_mem_en", mem_en, 0);
    check_eq("rs_mem_addr", mem_addr, 0);
    check_eq("rs_mem_wdata", mem_wdata, 0);
    check_eq("rs_owner", owner, 1);
    check_eq("rs_a_rdata", a_rdata, 0);
    tick();
    check_eq("rs_no_ack", a_ack, 0);
    tick();
    check_eq("rs_no_write", mem[10'h003], 16'h1111);
    reset = 1'b1;
    tick();
    check_eq("rs_re_en", mem_en, 1);
    check_eq("rs_re_we", mem_we, 1);
    check_eq("rs_re_addr", mem_addr, 10'h003);
    tick();
    check_eq("rs_re_ack", a_ack, 1);
    a_req = 1'b0; a_we = 1'b0;
    tick();
    check_eq("rs_re_content", mem[10'h003], 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 10, giving the word-address width of the shared memory.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 16, giving the word width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 a_req  input  1  port A (CPU fetch/load/store) request, held high until a_ack.
REQ-006 a_we  input  1  port A write enable, qualified by a_req.
REQ-007 a_addr  input  ADDR_WIDTH  port A word address.
REQ-008 a_wdata  input  DATA_WIDTH  port A write data.
REQ-009 a_rdata  output  DATA_WIDTH  port A registered read data.
REQ-010 a_ack  output  1  port A one-cycle completion pulse.
REQ-011 b_req, b_we, b_addr, b_wdata, b_rdata, b_ack SHALL exist for port B (program loader), with the same widths and meanings as port A.
REQ-012 mem_en  output  1  shared-memory access strobe.
REQ-013 mem_we  output  1  shared-memory write strobe.
REQ-014 mem_addr  output  ADDR_WIDTH  shared-memory address.
REQ-015 mem_wdata  output  DATA_WIDTH  shared-memory write data.
REQ-016 mem_rdata  input  DATA_WIDTH  shared-memory read data, valid one cycle after mem_en.
REQ-017 owner  output  1  port of the current or last grant: 0 = A, 1 = B.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ISSUE and ACK.
REQ-019 In IDLE with neither request high, the FSM SHALL stay in IDLE, with mem_en, mem_we and both acks low.
REQ-020 In IDLE with at least one request high, the FSM SHALL select a winner, latch the winner's we, addr and wdata, set owner, and go to ISSUE.
REQ-021 When both requests are high in the same IDLE cycle, the winner SHALL be the port not granted last (round-robin).
REQ-022 When only one request is high, that port SHALL win regardless of grant history.
REQ-023 In ISSUE, mem_en SHALL be 1, mem_we SHALL equal the latched we, mem_addr and mem_wdata SHALL equal the latched values, and the FSM SHALL go to ACK.
REQ-024 In ACK, the winner's ack SHALL be 1 for exactly one cycle, the FSM SHALL return to IDLE, and mem_en and mem_we SHALL be 0.
REQ-025 For a read, the winner's rdata SHALL be loaded from mem_rdata at the ISSUE->ACK edge and held until that port's next completed read.
REQ-026 For a write, the winner's rdata SHALL remain unchanged.
REQ-027 The loser's ack and rdata SHALL be unchanged throughout the transaction.
REQ-028 Latency: a request sampled in IDLE at edge N SHALL give mem_en high in cycle N..N+1 and ack high in cycle N+1..N+2.
REQ-029 Maximum throughput SHALL be one transaction per 3 cycles.
REQ-030 A request still high during its ACK cycle SHALL be treated in the following IDLE cycle as a new transaction.
REQ-031 Request and address changes after the IDLE sampling edge SHALL NOT affect the transaction in flight.
REQ-032 A request dropped during ISSUE or ACK SHALL NOT abort the transaction; it completes and its ack is still pulsed.
REQ-033 Address arithmetic SHALL NOT be performed; addresses SHALL pass through unmodified at ADDR_WIDTH.
REQ-034 mem_en, mem_we and the acks SHALL be driven from registers, with no combinational path from any input.

Reset
REQ-035 While reset is low, the FSM SHALL be in IDLE.
REQ-036 While reset is low, mem_en, mem_we, a_ack and b_ack SHALL be 0.
REQ-037 While reset is low, mem_addr, mem_wdata, a_rdata and b_rdata SHALL be 0, and owner SHALL be 1, so that A wins the first contention.
REQ-038 Reset asserted mid-transaction SHALL abort it immediately with no ack and no write strobe; the requester SHALL re-request after reset is released.
REQ-039 After reset is released, the first rising edge SHALL sample requests normally.

Verification
REQ-040 Single read: memory word 0x005 = 0x8000; a_req=1, a_we=0, a_addr=0x005 -> mem_en pulses 1 cycle with mem_addr=0x005, and the next cycle a_ack=1 with a_rdata=0x8000.
REQ-041 Single write: b_req=1, b_we=1, b_addr=0x00A, b_wdata=0x1234 -> mem_en=mem_we=1 for one cycle with addr 0x00A, then b_ack=1 and b_rdata unchanged.
REQ-042 Contention after reset: both requests high on the first edge -> A is served first (owner=0), then B (owner=1), with no IDLE gap beyond the single IDLE cycle.
REQ-043 Sustained contention: both requests held high for 12 cycles -> grants strictly alternate A, B, A, B, each ack 3 cycles apart, and neither port starves.
REQ-044 Request withdrawn: a_req dropped during ISSUE -> a_ack still pulses once, and no second transaction starts.
REQ-045 Reset during ISSUE of a write -> mem_we goes 0 immediately, no ack, all outputs take reset values, and a re-request after release completes normally.
